// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: arbiter state encoding, Wishbone width codes
// and the fixed master indices of the fetch and load/store engines.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10,
    ST_ABORT  = 2'b11
  } arb_state_e;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  localparam int M_FETCH = 0;
  localparam int M_DATA  = 1;

  // One-hot grant code for a single-bit owner index (0 = fetch, 1 = data).
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// One Wishbone link. The initiator uses the master modport; the arbiter
// takes each CPU engine on a slave modport and drives the system bus
// through a master modport. err only exists on the arbiter->engine side.
interface wb_master_arbiter_if;
  import cpu_bus_pkg::*;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic [1:0]  width;
  logic [31:0] rdata;
  logic        ack;
  logic        stl;
  logic        err;

  modport master (
    output cyc, stb, we, addr, data, width,
    input  rdata, ack, stl
  );

  modport slave (
    input  cyc, stb, we, addr, data, width,
    output rdata, ack, stl, err
  );

endinterface

// File: rtl/arb_watchdog.sv
// Bus-cycle watchdog: counts granted cycles without an acknowledge and
// flags the cycle in which the limit is reached. TIMEOUT = 0 disables it.
module arb_watchdog
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  // Idle/abort and every ack restart the count; otherwise count up and saturate.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= {TIMEOUT_W{1'b0}};
    end else if (!active || ack) begin
      count <= {TIMEOUT_W{1'b0}};
    end else if (count != CNT_MAX) begin
      count <= count + TIMEOUT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign o_expired = (TIMEOUT != 0) && active && !ack && (count == CNT_LAST);

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master / one-slave Wishbone arbiter between the instruction-fetch
// engine (m0) and the load/store engine (m1). The grant is held for the
// whole cyc envelope; responses reach only the owner; a watchdog turns a
// hung cycle into an err pulse followed by an ABORT hold.
module wb_master_arbiter
  import cpu_bus_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0,
  parameter int TIMEOUT     = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_master_arbiter_if.slave   m0,
  wb_master_arbiter_if.slave   m1,
  wb_master_arbiter_if.master  wb,
  output logic [1:0]           o_grant,
  output logic                 o_busy
);

  arb_state_e state;
  arb_state_e state_next;
  // Master served most recently (also the owner while in ABORT).
  logic       last;
  logic       last_next;
  logic       granted;
  logic       expired;

  assign granted = (state == ST_GRANT0) || (state == ST_GRANT1);

  arb_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .active    (granted),
    .ack       (wb.ack),
    .o_expired (expired)
  );

  // State and last-served registers; reset lets m0 win the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Next-state: arbitration in IDLE, release/timeout in GRANTn, drain in ABORT.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      ST_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          if (ROUND_ROBIN) begin
            state_next = last ? ST_GRANT0 : ST_GRANT1;
          end else begin
            state_next = ST_GRANT1;
          end
        end else if (m0.cyc) begin
          state_next = ST_GRANT0;
        end else if (m1.cyc) begin
          state_next = ST_GRANT1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        if (!m0.cyc) begin
          state_next = ST_IDLE;
          last_next  = 1'b0;
        end else if (expired) begin
          state_next = ST_ABORT;
          last_next  = 1'b0;
        end else begin
          state_next = ST_GRANT0;
        end
      end
      ST_GRANT1: begin
        if (!m1.cyc) begin
          state_next = ST_IDLE;
          last_next  = 1'b1;
        end else if (expired) begin
          state_next = ST_ABORT;
          last_next  = 1'b1;
        end else begin
          state_next = ST_GRANT1;
        end
      end
      ST_ABORT: begin
        if (!(last ? m1.cyc : m0.cyc)) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_ABORT;
        end
      end
      default: begin
        state_next = ST_IDLE;
        last_next  = 1'b1;
      end
    endcase
  end

  // Bus and response routing: owner passes through, everyone else is stalled.
  always_comb begin
    wb.cyc   = 1'b0;
    wb.stb   = 1'b0;
    wb.we    = 1'b0;
    wb.addr  = 32'h0000_0000;
    wb.data  = 32'h0000_0000;
    wb.width = 2'b00;
    m0.ack   = 1'b0;
    m0.stl   = m0.cyc;
    m0.err   = 1'b0;
    m1.ack   = 1'b0;
    m1.stl   = m1.cyc;
    m1.err   = 1'b0;
    o_grant  = 2'b00;
    case (state)
      ST_GRANT0: begin
        wb.cyc   = m0.cyc;
        wb.stb   = m0.stb;
        wb.we    = m0.we;
        wb.addr  = m0.addr;
        wb.data  = m0.data;
        wb.width = m0.width;
        m0.ack   = wb.ack;
        m0.stl   = wb.stl;
        m0.err   = expired;
        o_grant  = owner_onehot(1'b0);
      end
      ST_GRANT1: begin
        wb.cyc   = m1.cyc;
        wb.stb   = m1.stb;
        wb.we    = m1.we;
        wb.addr  = m1.addr;
        wb.data  = m1.data;
        wb.width = m1.width;
        m1.ack   = wb.ack;
        m1.stl   = wb.stl;
        m1.err   = expired;
        o_grant  = owner_onehot(1'b1);
      end
      ST_ABORT: begin
        if (last) begin
          m1.stl = 1'b1;
        end else begin
          m0.stl = 1'b1;
        end
        o_grant = owner_onehot(last);
      end
      ST_IDLE: begin
        o_grant = 2'b00;
      end
      default: begin
        o_grant = 2'b00;
      end
    endcase
  end

  // Read data is broadcast; only the ack-qualified owner consumes it.
  assign m0.rdata = wb.rdata;
  assign m1.rdata = wb.rdata;
  assign o_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench: two arbiters (fixed priority with TIMEOUT=4, and
// round-robin with the watchdog off) see the same master/slave stimulus;
// every cycle both are compared with a cycle-level reference model.
module tb_wb_master_arbiter;
  import cpu_bus_pkg::*;

  typedef struct packed {
    logic        cyc, stb, we;
    logic [31:0] addr, data;
    logic [1:0]  width;
    logic        ack0, stl0, err0, ack1, stl1, err1;
    logic [31:0] rd0, rd1;
    logic [1:0]  grant;
    logic        busy;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  c, s, w;
  logic [31:0] a [2];
  logic [31:0] d [2];
  logic [1:0]  wd [2];
  logic        wack, wstl;
  logic [31:0] wrd;
  logic [1:0]  grant_a, grant_b;
  logic        busy_a, busy_b;
  int          checks = 0;
  int          errors = 0;

  // Reference model state per instance: phase 0 idle / 1 granted / 2 abort.
  int mph [2], mown [2], mlst [2], mcnt [2], mrr [2], mtmo [2];

  always #5 clk = ~clk;

  wb_master_arbiter_if m0a(), m1a(), wba(), m0b(), m1b(), wbb();

  assign m0a.cyc = c[0]; assign m0a.stb = s[0]; assign m0a.we = w[0];
  assign m0a.addr = a[0]; assign m0a.data = d[0]; assign m0a.width = wd[0];
  assign m1a.cyc = c[1]; assign m1a.stb = s[1]; assign m1a.we = w[1];
  assign m1a.addr = a[1]; assign m1a.data = d[1]; assign m1a.width = wd[1];
  assign m0b.cyc = c[0]; assign m0b.stb = s[0]; assign m0b.we = w[0];
  assign m0b.addr = a[0]; assign m0b.data = d[0]; assign m0b.width = wd[0];
  assign m1b.cyc = c[1]; assign m1b.stb = s[1]; assign m1b.we = w[1];
  assign m1b.addr = a[1]; assign m1b.data = d[1]; assign m1b.width = wd[1];
  assign wba.rdata = wrd; assign wba.ack = wack; assign wba.stl = wstl; assign wba.err = 1'b0;
  assign wbb.rdata = wrd; assign wbb.ack = wack; assign wbb.stl = wstl; assign wbb.err = 1'b0;

  wb_master_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(4), .TIMEOUT_W(8)) dut_a (
    .clk(clk), .reset(reset), .m0(m0a), .m1(m1a), .wb(wba), .o_grant(grant_a), .o_busy(busy_a));
  wb_master_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(0), .TIMEOUT_W(8)) dut_b (
    .clk(clk), .reset(reset), .m0(m0b), .m1(m1b), .wb(wbb), .o_grant(grant_b), .o_busy(busy_b));

  obs_t act_a, act_b;
  assign act_a = {wba.cyc, wba.stb, wba.we, wba.addr, wba.data, wba.width,
                  m0a.ack, m0a.stl, m0a.err, m1a.ack, m1a.stl, m1a.err,
                  m0a.rdata, m1a.rdata, grant_a, busy_a};
  assign act_b = {wbb.cyc, wbb.stb, wbb.we, wbb.addr, wbb.data, wbb.width,
                  m0b.ack, m0b.stl, m0b.err, m1b.ack, m1b.stl, m1b.err,
                  m0b.rdata, m1b.rdata, grant_b, busy_b};

  // Hung-cycle rule: T-th granted cycle without ack since grant or last ack.
  function automatic logic model_err(int k);
    return (mph[k] == 1) && (mtmo[k] != 0) && (mcnt[k] == mtmo[k] - 1) && !wack;
  endfunction

  function automatic obs_t model_out(int k);
    obs_t e;
    int   o;
    e = '0;
    e.rd0  = wrd;
    e.rd1  = wrd;
    e.stl0 = c[0];
    e.stl1 = c[1];
    e.busy = (mph[k] != 0);
    o = mown[k];
    if (mph[k] == 1) begin
      e.cyc = c[o]; e.stb = s[o]; e.we = w[o];
      e.addr = a[o]; e.data = d[o]; e.width = wd[o];
      e.grant = (o == 0) ? 2'b01 : 2'b10;
      if (o == 0) begin
        e.ack0 = wack; e.stl0 = wstl; e.err0 = model_err(k);
      end else begin
        e.ack1 = wack; e.stl1 = wstl; e.err1 = model_err(k);
      end
    end else if (mph[k] == 2) begin
      e.grant = (o == 0) ? 2'b01 : 2'b10;
      if (o == 0) e.stl0 = 1'b1;
      else e.stl1 = 1'b1;
    end
    return e;
  endfunction

  task automatic model_step();
    logic er;
    for (int k = 0; k < 2; k++) begin
      er = model_err(k);
      if (!reset) begin
        mph[k] = 0; mcnt[k] = 0; mlst[k] = 1;
      end else if (mph[k] == 0) begin
        if (c[0] && c[1]) begin
          mown[k] = (mrr[k] != 0) ? ((mlst[k] == 1) ? 0 : 1) : 1;
          mph[k] = 1; mcnt[k] = 0;
        end else if (c[0] || c[1]) begin
          mown[k] = c[0] ? 0 : 1;
          mph[k] = 1; mcnt[k] = 0;
        end
      end else if (mph[k] == 1) begin
        if (!c[mown[k]]) begin
          mph[k] = 0; mlst[k] = mown[k]; mcnt[k] = 0;
        end else if (er) begin
          mph[k] = 2; mlst[k] = mown[k]; mcnt[k] = 0;
        end else begin
          mcnt[k] = wack ? 0 : ((mcnt[k] < 255) ? mcnt[k] + 1 : 255);
        end
      end else begin
        if (!c[mown[k]]) mph[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    obs_t  e, x;
    string p;
    for (int k = 0; k < 2; k++) begin
      e = model_out(k);
      x = (k == 0) ? act_a : act_b;
      p = $sformatf("%s.%s", ph, (k == 0) ? "a" : "b");
      chk({p, ".wb_cyc"}, x.cyc, e.cyc);     chk({p, ".wb_stb"}, x.stb, e.stb);
      chk({p, ".wb_we"}, x.we, e.we);        chk({p, ".wb_addr"}, x.addr, e.addr);
      chk({p, ".wb_data"}, x.data, e.data);  chk({p, ".wb_width"}, x.width, e.width);
      chk({p, ".m0_ack"}, x.ack0, e.ack0);   chk({p, ".m0_stl"}, x.stl0, e.stl0);
      chk({p, ".m0_err"}, x.err0, e.err0);   chk({p, ".m1_ack"}, x.ack1, e.ack1);
      chk({p, ".m1_stl"}, x.stl1, e.stl1);   chk({p, ".m1_err"}, x.err1, e.err1);
      chk({p, ".m0_data"}, x.rd0, e.rd0);    chk({p, ".m1_data"}, x.rd1, e.rd1);
      chk({p, ".grant"}, x.grant, e.grant);  chk({p, ".busy"}, x.busy, e.busy);
    end
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1 ns later.
  task automatic settle(input string ph);
    #1;
    check_all(ph);
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c = 2'b00; s = 2'b00; w = 2'b00; wack = 1'b0; wstl = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    settle("rst");
    advance();
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] seen [$];
    logic [1:0] prevg;
    int         held [2];
    int         rem [2];
    logic       errflag [2];
    obs_t       e0;

    for (int k = 0; k < 2; k++) begin
      mph[k] = 0; mown[k] = 0; mlst[k] = 1; mcnt[k] = 0;
      a[k] = 32'h0; d[k] = 32'h0; wd[k] = WIDTH_WORD;
    end
    mrr[0] = 0; mtmo[0] = 4;
    mrr[1] = 1; mtmo[1] = 0;
    wrd = 32'h0;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);

    // Reset state, then the IDLE stall rule with both cyc high under reset.
    settle("reset");
    chk("reset_grant", grant_a, 2'b00);
    chk("reset_busy", busy_a, 1'b0);
    advance();
    c = 2'b11;
    settle("reset_stl");
    chk("reset_stl_m0", m0a.stl, 1'b1);
    chk("reset_stl_m1", m1b.stl, 1'b1);
    advance();

    // m0 reads 0xb0000000, slave acks two cycles after stb.
    do_reset();
    c[0] = 1'b1; s[0] = 1'b1; w[0] = 1'b0; a[0] = 32'hb000_0000; wd[0] = WIDTH_WORD;
    settle("t1_req");
    chk("t1_req_wb_cyc", wba.cyc, 1'b0);
    advance();
    settle("t1_grant");
    chk("t1_grant", grant_a, 2'b01);
    chk("t1_wb_stb", wba.stb, 1'b1);
    chk("t1_wb_addr", wba.addr, 32'hb000_0000);
    advance();
    settle("t1_wait");
    advance();
    wack = 1'b1; wrd = 32'h1234_5678;
    settle("t1_ack");
    chk("t1_m0_ack", m0a.ack, 1'b1);
    chk("t1_m0_data", m0a.rdata, 32'h1234_5678);
    chk("t1_m1_ack", m1a.ack, 1'b0);
    advance();
    wack = 1'b0; c[0] = 1'b0; s[0] = 1'b0;
    settle("t1_release");
    chk("t1_release_cyc", wba.cyc, 1'b0);
    advance();
    settle("t1_idle");
    chk("t1_idle_busy", busy_a, 1'b0);
    advance();

    // Simultaneous requests: fixed priority serves m1 first, m0 waits stalled.
    do_reset();
    c = 2'b11; s = 2'b11; a[1] = 32'hb000_0100;
    settle("t2_req");
    advance();
    for (int i = 0; i < 3; i++) begin
      settle("t2_hold");
      chk("t2_grant_fixed", grant_a, 2'b10);
      chk("t2_grant_rr", grant_b, 2'b01);
      chk("t2_m0_stl", m0a.stl, 1'b1);
      advance();
    end
    c[1] = 1'b0; s[1] = 1'b0;
    settle("t2_drop");
    chk("t2_drop_cyc", wba.cyc, 1'b0);
    chk("t2_drop_m0_stl", m0a.stl, 1'b1);
    advance();
    settle("t2_gap");
    chk("t2_gap_grant", grant_a, 2'b00);
    chk("t2_gap_m0_stl", m0a.stl, 1'b1);
    advance();
    settle("t2_next");
    chk("t2_next_grant", grant_a, 2'b01);
    advance();
    idle_inputs();
    settle("t2_end");
    advance();

    // Round robin with both masters requesting back to back.
    do_reset();
    held[0] = 0; held[1] = 0;
    prevg = 2'b00;
    for (int i = 0; i < 24; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (mph[1] == 1 && mown[1] == n) begin
          if (held[n] == 2) begin
            c[n] = 1'b0; held[n] = 0;
          end else begin
            c[n] = 1'b1; held[n]++;
          end
        end else begin
          c[n] = 1'b1;
        end
      end
      s = c;
      settle("t3");
      if (grant_b != 2'b00 && prevg == 2'b00) seen.push_back(grant_b);
      prevg = grant_b;
      advance();
    end
    chk("t3_grant_count", (seen.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int j = 0; j < 4; j++) begin
      if (j < seen.size()) chk($sformatf("t3_grant_%0d", j), seen[j], (j % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle_inputs();
    settle("t3_end");
    advance();
    settle("t3_end2");
    advance();

    // m1 word write held off by slave stall for three cycles.
    do_reset();
    c[1] = 1'b1; s[1] = 1'b1; w[1] = 1'b1; a[1] = 32'hb000_fffc; d[1] = 32'hdead_beef;
    wd[1] = WIDTH_WORD; wstl = 1'b1;
    settle("t4_req");
    advance();
    for (int i = 0; i < 3; i++) begin
      settle("t4_stall");
      chk("t4_wb_we", wba.we, 1'b1);
      chk("t4_wb_addr", wba.addr, 32'hb000_fffc);
      chk("t4_wb_data", wba.data, 32'hdead_beef);
      chk("t4_wb_width", wba.width, WIDTH_WORD);
      chk("t4_m1_stl", m1a.stl, 1'b1);
      advance();
    end
    wstl = 1'b0; wack = 1'b1;
    settle("t4_ack");
    chk("t4_m1_ack", m1a.ack, 1'b1);
    chk("t4_m1_stl_low", m1a.stl, 1'b0);
    chk("t4_m1_err", m1a.err, 1'b0);
    advance();
    idle_inputs();
    settle("t4_end");
    advance();

    // Watchdog: slave never acks, TIMEOUT=4 on instance a.
    do_reset();
    c[0] = 1'b1; s[0] = 1'b1;
    settle("t5_req");
    advance();
    for (int i = 1; i <= 4; i++) begin
      settle("t5_granted");
      chk($sformatf("t5_err_cycle%0d", i), m0a.err, (i == 4) ? 1'b1 : 1'b0);
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      settle("t5_abort");
      chk("t5_abort_cyc", wba.cyc, 1'b0);
      chk("t5_abort_busy", busy_a, 1'b1);
      chk("t5_abort_stl", m0a.stl, 1'b1);
      chk("t5_abort_err", m0a.err, 1'b0);
      advance();
    end
    c[0] = 1'b0; s[0] = 1'b0;
    settle("t5_drop");
    advance();
    settle("t5_idle");
    chk("t5_idle_busy", busy_a, 1'b0);
    advance();

    // Reset while m1 owns the bus; the late ack must be discarded.
    do_reset();
    c[1] = 1'b1; s[1] = 1'b1;
    settle("t6_req");
    advance();
    settle("t6_grant");
    chk("t6_grant", grant_a, 2'b10);
    advance();
    reset = 1'b0;
    settle("t6_reset");
    advance();
    reset = 1'b1; wack = 1'b1; c = 2'b01; s = 2'b01;
    settle("t6_after");
    chk("t6_after_grant", grant_a, 2'b00);
    chk("t6_after_busy", busy_a, 1'b0);
    chk("t6_after_cyc", wba.cyc, 1'b0);
    chk("t6_late_ack", m1a.ack, 1'b0);
    advance();
    wack = 1'b0;
    settle("t6_regrant");
    chk("t6_regrant", grant_a, 2'b01);
    advance();
    idle_inputs();
    settle("t6_end");
    advance();

    // Random traffic; masters obey err from instance a by dropping cyc.
    rem[0] = 0; rem[1] = 0; errflag[0] = 1'b0; errflag[1] = 1'b0;
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(99) != 0);
      for (int n = 0; n < 2; n++) begin
        if (c[n]) begin
          if (rem[n] == 0 || errflag[n]) c[n] = 1'b0;
          else rem[n]--;
        end else if ($urandom_range(2) == 0) begin
          c[n] = 1'b1;
          rem[n] = int'($urandom_range(12, 1));
        end
        s[n] = c[n] & 1'($urandom_range(1));
        w[n] = 1'($urandom_range(1));
        a[n] = $urandom;
        d[n] = $urandom;
        wd[n] = 2'($urandom_range(3));
      end
      wack = ($urandom_range(3) == 0);
      wstl = ($urandom_range(3) == 0);
      wrd = $urandom;
      settle("rnd");
      e0 = model_out(0);
      errflag[0] = e0.err0;
      errflag[1] = e0.err1;
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
